mem_access_unit: RTL and testbench

- MEM-stage load/store initiator that drives the byte-addressed, little-endian data memory port (WriteSig/ReadSig/address/WriteData/outData), which acts on the negedge of clk.
- Accepts one load/store per handshake from the pipeline and handles byte, halfword and word sizes.
- Sub-word stores use read-modify-write, because the memory always writes 4 bytes at `address`.
- Returns sign/zero-extended load data and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline load/store handshake plus the byte-addressed data memory port.
// The slave modport is the access unit; the master side is the pipeline
// together with the memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_WriteData;
  logic        mem_WriteSig;
  logic        mem_ReadSig;
  logic [31:0] mem_outData;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_outData,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_address, mem_WriteData, mem_WriteSig, mem_ReadSig
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_outData,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_address, mem_WriteData, mem_WriteSig, mem_ReadSig
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator. Drives a little-endian data memory that
// acts on the negedge of clk and always writes four bytes, so byte and
// halfword stores are done as read-modify-write. Misaligned, out-of-range
// and illegal-size requests are answered with an error and never reach
// the memory.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, RMW_READ, WRITE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        write_sig_q, write_sig_d;
  logic        read_sig_q, read_sig_d;
  logic        req_err;

  // Lane 0 holds the addressed data because the read is issued at addr.
  function automatic logic [31:0] extend(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {{24{sgn & d[7]}}, d[7:0]};
      SZ_HALF: return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Error detection on the request as presented at accept.
  always_comb begin
    req_err = (bus.req_addr > 32'(MEM_BYTES - 4));
    case (bus.req_size)
      SZ_HALF: req_err = req_err | bus.req_addr[0];
      SZ_WORD: req_err = req_err | (bus.req_addr[1:0] != 2'b00);
      SZ_BAD:  req_err = 1'b1;
      default: ;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    write_sig_d  = 1'b0;
    read_sig_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          wdata_d  = bus.req_wdata;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!bus.req_write) begin
            address_d  = bus.req_addr;
            read_sig_d = 1'b1;
            state_d    = READ;
          end else if (bus.req_size == SZ_WORD) begin
            address_d    = bus.req_addr;
            write_data_d = bus.req_wdata;
            write_sig_d  = 1'b1;
            state_d      = WRITE;
          end else begin
            address_d  = bus.req_addr;
            read_sig_d = 1'b1;
            state_d    = RMW_READ;
          end
        end
      end
      READ: begin
        resp_rdata_d = extend(size_q, signed_q, bus.mem_outData);
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      RMW_READ: begin
        write_data_d = (size_q == SZ_BYTE) ? {bus.mem_outData[31:8], wdata_q[7:0]}
                                           : {bus.mem_outData[31:16], wdata_q[15:0]};
        write_sig_d  = 1'b1;
        state_d      = WRITE;
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops both strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      write_sig_q  <= 1'b0;
      read_sig_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      write_sig_q  <= write_sig_d;
      read_sig_q   <= read_sig_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.mem_address   = address_q;
  assign bus.mem_WriteData = write_data_q;
  assign bus.mem_WriteSig  = write_sig_q;
  assign bus.mem_ReadSig   = read_sig_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a negedge-acting byte memory, a byte-array
// reference model of the specified load/store rules, directed scenarios
// and a randomized request stream.
module tb_mem_access_unit;
  localparam int MEM_BYTES = 1024;

  logic clk;
  logic rst_n;
  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          rd;
    int          wr;
    int          both;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
  } obs_t;

  // Data memory: acts on the negedge, always four bytes at address.
  always @(negedge clk) begin
    int a;
    a = int'(bus.mem_address);
    if (bus.mem_WriteSig && bus.mem_address <= 32'(MEM_BYTES - 4))
      for (int i = 0; i < 4; i++) mem[a+i] <= bus.mem_WriteData[8*i +: 8];
    if (bus.mem_ReadSig && bus.mem_address <= 32'(MEM_BYTES - 4))
      bus.mem_outData <= {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  end

  task automatic preload(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a+i]     = w[8*i +: 8];
      ref_mem[a+i] = w[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  // Reference model: applies one request to ref_mem and predicts the response.
  task automatic ref_apply(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic e, output logic [31:0] rd, output int lat,
                           output logic [31:0] wimg);
    int n;
    int ai;
    longint val;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || ((a % 32'(n)) != 0) || (a > 32'(MEM_BYTES - 4));
    rd = '0;
    wimg = '0;
    lat = 0;
    if (e) return;
    ai = int'(a);
    if (!w) begin
      val = 0;
      for (int i = 0; i < n; i++) val += longint'(ref_mem[ai+i]) << (8*i);
      if (sg && n < 4 && val >= (longint'(1) << (8*n-1))) val -= longint'(1) << (8*n);
      rd  = val[31:0];
      lat = 1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[ai+i] = wd[8*i +: 8];
      wimg = ref_word(ai);
      lat  = (n == 4) ? 1 : 2;
    end
  endtask

  // Issues one request from IDLE and watches the bus until the response.
  // Sample k=0 is just after the accept edge; lat=-1 means no response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output obs_t o);
    o.lat = -1; o.err = 1'b0; o.rdata = '0; o.rd = 0; o.wr = 0; o.both = 0;
    o.wr_data = '0; o.wr_addr = '0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.mem_ReadSig) o.rd++;
      if (bus.mem_WriteSig) begin
        o.wr++;
        o.wr_data = bus.mem_WriteData;
        o.wr_addr = bus.mem_address;
      end
      if (bus.mem_ReadSig && bus.mem_WriteSig) o.both++;
      if (bus.resp_valid) begin
        o.lat = k; o.err = bus.resp_err; o.rdata = bus.resp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready); else n_pass++;
    n_checks++; if ({bus.resp_valid, bus.resp_err} !== 2'b00) $display("FAIL reset_resp got %b want 00", {bus.resp_valid, bus.resp_err}); else n_pass++;
    n_checks++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); else n_pass++;
    n_checks++; if ({bus.mem_address, bus.mem_WriteData} !== 64'h0) $display("FAIL reset_mem_bus got %h/%h want 0/0", bus.mem_address, bus.mem_WriteData); else n_pass++;
    n_checks++; if ({bus.mem_WriteSig, bus.mem_ReadSig} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {bus.mem_WriteSig, bus.mem_ReadSig}); else n_pass++;
  endtask

  task automatic test_word_store_load();
    obs_t o;
    logic e; logic [31:0] rd, wimg; int lat;
    ref_apply(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, e, rd, lat, wimg);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, o);
    n_checks++; if (o.lat !== 1 || o.err !== 1'b0) $display("FAIL wstore_resp got lat=%0d err=%b want lat=1 err=0", o.lat, o.err); else n_pass++;
    n_checks++; if (o.wr !== 1 || o.rd !== 0) $display("FAIL wstore_strobes got wr=%0d rd=%0d want wr=1 rd=0", o.wr, o.rd); else n_pass++;
    n_checks++; if (o.wr_data !== 32'hDEADBEEF || o.wr_addr !== 32'h10) $display("FAIL wstore_bus got %h@%h want deadbeef@10", o.wr_data, o.wr_addr); else n_pass++;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, o);
    n_checks++; if (o.lat !== 1 || o.err !== 1'b0) $display("FAIL wload_resp got lat=%0d err=%b want lat=1 err=0", o.lat, o.err); else n_pass++;
    n_checks++; if (o.rdata !== 32'hDEADBEEF) $display("FAIL wload_data got %h want deadbeef", o.rdata); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL resp_pulse got %b want 0", bus.resp_valid); else n_pass++;
  endtask

  task automatic test_byte_rmw();
    obs_t o;
    logic e; logic [31:0] rd, wimg; int lat;
    preload(32'h20, 32'h11223344);
    ref_apply(1'b1, 2'd0, 1'b0, 32'h20, 32'h000000AB, e, rd, lat, wimg);
    issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h000000AB, o);
    n_checks++; if (o.lat !== 2 || o.err !== 1'b0) $display("FAIL rmw_resp got lat=%0d err=%b want lat=2 err=0", o.lat, o.err); else n_pass++;
    n_checks++; if (o.rd !== 1 || o.wr !== 1 || o.both !== 0) $display("FAIL rmw_strobes got rd=%0d wr=%0d both=%0d want 1/1/0", o.rd, o.wr, o.both); else n_pass++;
    n_checks++; if (o.wr_data !== 32'h112233AB) $display("FAIL rmw_wdata got %h want 112233ab", o.wr_data); else n_pass++;
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, o);
    n_checks++; if (o.rdata !== 32'h112233AB) $display("FAIL rmw_readback got %h want 112233ab", o.rdata); else n_pass++;
  endtask

  task automatic test_extension();
    obs_t o;
    logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF080, 32'h0000F080};
    preload(32'h30, 32'h0000F080);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], sg[i], 32'h30, 32'h0, o);
      n_checks++; if (o.rdata !== exp[i] || o.lat !== 1) $display("FAIL ext_%0d got %h lat=%0d want %h lat=1", i, o.rdata, o.lat, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic        w  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] a  [4] = '{32'h41, 32'h42, 32'h3FD, 32'h10};
    for (int i = 0; i < 4; i++) begin
      issue(w[i], sz[i], 1'b0, a[i], 32'h12345678, o);
      n_checks++; if (o.lat !== 0 || o.err !== 1'b1 || o.rdata !== 32'h0) $display("FAIL err_%0d got lat=%0d err=%b rdata=%h want 0/1/0", i, o.lat, o.err, o.rdata); else n_pass++;
      n_checks++; if (o.rd !== 0 || o.wr !== 0) $display("FAIL err_strobe_%0d got rd=%0d wr=%0d want 0/0", i, o.rd, o.wr); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic e; logic [31:0] rd1, rd2, wimg1, wimg2; int lat;
    preload(32'h60, 32'h55667788);
    preload(32'h64, 32'h0BADF00D);
    ref_apply(1'b1, 2'd0, 1'b0, 32'h60, 32'h123456A5, e, rd1, lat, wimg1);
    ref_apply(1'b0, 2'd2, 1'b0, 32'h64, 32'h0, e, rd2, lat, wimg2);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h60; bus.req_wdata = 32'h123456A5;
    @(posedge clk); #1;
    bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h64; bus.req_wdata = 32'hFFFFFFFF;
    n_checks++; if (bus.req_ready !== 1'b0 || bus.mem_ReadSig !== 1'b1) $display("FAIL b2b_busy0 got ready=%b rd=%b want 0/1", bus.req_ready, bus.mem_ReadSig); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b0 || bus.mem_WriteSig !== 1'b1) $display("FAIL b2b_busy1 got ready=%b wr=%b want 0/1", bus.req_ready, bus.mem_WriteSig); else n_pass++;
    n_checks++; if (bus.mem_WriteData !== wimg1) $display("FAIL b2b_wdata got %h want %h", bus.mem_WriteData, wimg1); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL b2b_resp1 got v=%b e=%b ready=%b want 1/0/1", bus.resp_valid, bus.resp_err, bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++; if (bus.mem_ReadSig !== 1'b1 || bus.mem_address !== 32'h64 || bus.resp_valid !== 1'b0) $display("FAIL b2b_accept2 got rd=%b addr=%h v=%b want 1/64/0", bus.mem_ReadSig, bus.mem_address, bus.resp_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd2) $display("FAIL b2b_resp2 got v=%b data=%h want 1/%h", bus.resp_valid, bus.resp_rdata, rd2); else n_pass++;
    n_checks++; if ({mem[16'h63], mem[16'h62], mem[16'h61], mem[16'h60]} !== ref_word(32'h60)) $display("FAIL b2b_mem got %h want %h", {mem[16'h63], mem[16'h62], mem[16'h61], mem[16'h60]}, ref_word(32'h60)); else n_pass++;
  endtask

  task automatic test_reset_mid_rmw();
    obs_t o;
    preload(32'h50, 32'hCAFEF00D);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h50; bus.req_wdata = 32'h00000077;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++; if (bus.mem_ReadSig !== 1'b1) $display("FAIL rst_rmw_read got %b want 1", bus.mem_ReadSig); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.mem_ReadSig, bus.mem_WriteSig, bus.resp_valid} !== 3'b000 || bus.req_ready !== 1'b1) $display("FAIL rst_mid got rd/wr/v=%b ready=%b want 000/1", {bus.mem_ReadSig, bus.mem_WriteSig, bus.resp_valid}, bus.req_ready); else n_pass++;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({bus.resp_valid, bus.mem_WriteSig} !== 2'b00) $display("FAIL rst_after got v/wr=%b want 00", {bus.resp_valid, bus.mem_WriteSig}); else n_pass++;
    n_checks++; if ({mem[16'h53], mem[16'h52], mem[16'h51], mem[16'h50]} !== 32'hCAFEF00D) $display("FAIL rst_mem got %h want cafef00d", {mem[16'h53], mem[16'h52], mem[16'h51], mem[16'h50]}); else n_pass++;
    issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, o);
    n_checks++; if (o.rdata !== 32'hCAFEF00D || o.lat !== 1) $display("FAIL rst_readback got %h lat=%0d want cafef00d lat=1", o.rdata, o.lat); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    logic w, sg, e; logic [1:0] sz; logic [31:0] a, wd, rd, wimg; int lat, n, r;
    for (int it = 0; it < 60; it++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 15));
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC;
      wd = $urandom;
      ref_apply(w, sz, sg, a, wd, e, rd, lat, wimg);
      issue(w, sz, sg, a, wd, o);
      n_checks++; if (o.lat !== lat || o.err !== e) $display("FAIL rnd%0d_resp got lat=%0d err=%b want lat=%0d err=%b", it, o.lat, o.err, lat, e); else n_pass++;
      n_checks++; if (o.rd !== ((!e && (!w || sz != 2'd2)) ? 1 : 0) || o.wr !== ((!e && w) ? 1 : 0) || o.both !== 0) $display("FAIL rnd%0d_strobes got rd=%0d wr=%0d both=%0d", it, o.rd, o.wr, o.both); else n_pass++;
      if (!e && !w) begin
        n_checks++; if (o.rdata !== rd) $display("FAIL rnd%0d_rdata got %h want %h", it, o.rdata, rd); else n_pass++;
      end
      if (!e && w) begin
        n_checks++; if (o.wr_data !== wimg || o.wr_addr !== a) $display("FAIL rnd%0d_write got %h@%h want %h@%h", it, o.wr_data, o.wr_addr, wimg, a); else n_pass++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #3;
    test_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_word_store_load();
    test_byte_rmw();
    test_extension();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
